// File: rtl/mic_level_pkg.sv
// Shared widths, state type and arithmetic helpers for the microphone level meter.
package mic_level_pkg;

  localparam int SAMPLE_W = 16;
  localparam int LEVEL_W  = 32;

  typedef enum logic {
    FILL = 1'b0
  } win_state_e;

  // Magnitude of a signed sample, clamping -32768 to 0x7FFF so it fits 15 bits.
  function automatic logic [SAMPLE_W-1:0] sat_abs(input logic signed [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] mag;
    mag = $unsigned(-s);
    if (!s[SAMPLE_W-1]) return $unsigned(s);
    if (mag[SAMPLE_W-1]) return {1'b0, {(SAMPLE_W-1){1'b1}}};
    return mag;
  endfunction

  function automatic logic [15:0] umax16(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mic_level_meter_if.sv
// Sample stream in, packed level word out; the meter is the slave side.
interface mic_level_meter_if;
  import mic_level_pkg::*;

  logic signed [SAMPLE_W-1:0] sample_i;
  logic                       sample_valid_i;
  logic                       clear_i;
  logic [LEVEL_W-1:0]         level_o;
  logic                       level_valid_o;

  modport master (
    output sample_i, sample_valid_i, clear_i,
    input  level_o, level_valid_o
  );

  modport slave (
    input  sample_i, sample_valid_i, clear_i,
    output level_o, level_valid_o
  );
endinterface

// File: rtl/level_window_acc.sv
// Window stage: sums magnitudes, tracks the window peak and flags the last sample of each window.
module level_window_acc
  import mic_level_pkg::*;
#(
  parameter int WINDOW_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic [SAMPLE_W-1:0] abs_i,
  input  logic                abs_v_i,
  output logic [SAMPLE_W-1:0] mean_abs_o,
  output logic [SAMPLE_W-1:0] win_peak_o,
  output logic                end_o
);

  localparam int ACC_W = SAMPLE_W + WINDOW_LOG2;
  localparam logic [WINDOW_LOG2-1:0] CNT_LAST = '1;

  win_state_e              state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d, acc_sum;
  logic [WINDOW_LOG2-1:0]  cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]     peak_q, peak_d, peak_upd;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    peak_d   = peak_q;
    end_o    = 1'b0;
    acc_sum  = acc_q + ACC_W'(abs_i);
    peak_upd = umax16(peak_q, abs_i);
    // acc_sum never exceeds 2^W * 0x7FFF, so its top 16 bits are the truncated mean.
    mean_abs_o = acc_sum[ACC_W-1:WINDOW_LOG2];
    win_peak_o = peak_upd;

    case (state_q)
      FILL: begin
        if (abs_v_i) begin
          if (cnt_q == CNT_LAST) begin
            end_o   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            peak_d  = '0;
            state_d = FILL;
          end else begin
            acc_d  = acc_sum;
            cnt_d  = cnt_q + WINDOW_LOG2'(1);
            peak_d = peak_upd;
          end
        end
      end
      default: state_d = FILL;
    endcase

    // A restart drops the in-flight sample along with the partial window.
    if (clear_i) begin
      acc_d   = '0;
      cnt_d   = '0;
      peak_d  = '0;
      end_o   = 1'b0;
      state_d = FILL;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= FILL;
      acc_q   <= '0;
      cnt_q   <= '0;
      peak_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
    end
  end

endmodule

// File: rtl/mic_level_meter.sv
// Windowed loudness meter: mean absolute amplitude plus decaying peak hold, packed into one word per window.
module mic_level_meter
  import mic_level_pkg::*;
#(
  parameter int WINDOW_LOG2 = 10,
  parameter int DECAY_SHIFT = 3
) (
  input  logic              clk,
  input  logic              rst,
  mic_level_meter_if.slave  bus
);

  logic [SAMPLE_W-1:0] abs_q, abs_d;
  logic                abs_v_q, abs_v_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic                level_valid_q, level_valid_d;

  logic [SAMPLE_W-1:0] mean_abs, win_peak, decayed, new_peak;
  logic                win_end;

  always_comb begin
    abs_d   = abs_q;
    abs_v_d = 1'b0;
    if (bus.sample_valid_i) begin
      abs_d   = sat_abs(bus.sample_i);
      abs_v_d = 1'b1;
    end
    if (bus.clear_i) begin
      abs_d   = '0;
      abs_v_d = 1'b0;
    end
  end

  level_window_acc #(
    .WINDOW_LOG2 (WINDOW_LOG2)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (bus.clear_i),
    .abs_i      (abs_q),
    .abs_v_i    (abs_v_q),
    .mean_abs_o (mean_abs),
    .win_peak_o (win_peak),
    .end_o      (win_end)
  );

  always_comb begin
    decayed       = hold_q - (hold_q >> DECAY_SHIFT);
    new_peak      = umax16(win_peak, decayed);
    hold_d        = hold_q;
    level_d       = level_q;
    level_valid_d = 1'b0;
    if (win_end) begin
      hold_d        = new_peak;
      level_d       = {new_peak, mean_abs};
      level_valid_d = 1'b1;
    end
    if (bus.clear_i) begin
      hold_d        = '0;
      level_d       = '0;
      level_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      abs_q         <= '0;
      abs_v_q       <= 1'b0;
      hold_q        <= '0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
    end else begin
      abs_q         <= abs_d;
      abs_v_q       <= abs_v_d;
      hold_q        <= hold_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
    end
  end

  assign bus.level_o       = level_q;
  assign bus.level_valid_o = level_valid_q;

endmodule

// File: tb/tb_mic_level_meter.sv
// Directed and randomized checks of mic_level_meter against a window-level reference model.
module tb_mic_level_meter;

  localparam int WL   = 4;
  localparam int DS   = 2;
  localparam int WIN  = 1 << WL;

  logic clk = 1'b0;
  logic rst;

  mic_level_meter_if bus ();

  mic_level_meter #(
    .WINDOW_LOG2 (WL),
    .DECAY_SHIFT (DS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitor, sampled mid-cycle.
  int          pulse_cnt  = 0;
  logic [31:0] last_level = '0;
  always @(negedge clk) begin
    if (bus.level_valid_o === 1'b1) begin
      pulse_cnt  = pulse_cnt + 1;
      last_level = bus.level_o;
    end
  end

  // Reference model: works on whole windows of accepted samples.
  int win_q[$];
  int model_hold  = 0;
  int model_level = 0;
  int exp_pulses  = 0;

  function automatic int abs_sat(input int s);
    if (s == -32768) return 32767;
    return (s < 0) ? -s : s;
  endfunction

  task automatic model_clear();
    win_q.delete();
    model_hold  = 0;
    model_level = 0;
  endtask

  task automatic model_push(input int s);
    int sum;
    int peak;
    int decayed;
    win_q.push_back(abs_sat(s));
    if (win_q.size() == WIN) begin
      sum  = 0;
      peak = 0;
      foreach (win_q[i]) begin
        sum = sum + win_q[i];
        if (win_q[i] > peak) peak = win_q[i];
      end
      decayed     = model_hold - model_hold / (1 << DS);
      model_hold  = (peak > decayed) ? peak : decayed;
      model_level = model_hold * 65536 + sum / WIN;
      exp_pulses  = exp_pulses + 1;
      win_q.delete();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input int max_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (g) tick();
    bus.sample_i       = 16'(s);
    bus.sample_valid_i = 1'b1;
    tick();
    bus.sample_valid_i = 1'b0;
    model_push(s);
  endtask

  task automatic do_clear();
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    model_clear();
  endtask

  task automatic window_done(input string tag);
    tick();
    tick();
    check({tag, "_pulses"}, 32'(pulse_cnt), 32'(exp_pulses));
    check({tag, "_level"}, last_level, 32'(model_level));
  endtask

  initial begin
    int s;
    rst                = 1'b1;
    bus.sample_i       = '0;
    bus.sample_valid_i = 1'b0;
    bus.clear_i        = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("reset_level", bus.level_o, 32'h0);
    check("reset_valid", 32'(bus.level_valid_o), 32'h0);
    check("reset_pulses", 32'(pulse_cnt), 32'h0);

    // Constant +1000 back-to-back, with exact two-edge latency
    for (int i = 0; i < WIN - 1; i++) send(1000, 0);
    bus.sample_i       = 16'sd1000;
    bus.sample_valid_i = 1'b1;
    tick();
    bus.sample_valid_i = 1'b0;
    model_push(1000);
    check("const_no_pulse_e", 32'(bus.level_valid_o), 32'h0);
    tick();
    check("const_pulse_e1", 32'(bus.level_valid_o), 32'h1);
    check("const_level", bus.level_o, 32'h03E8_03E8);
    check("const_level_model", bus.level_o, 32'(model_level));
    tick();
    check("const_pulse_once", 32'(bus.level_valid_o), 32'h0);
    check("const_level_stable", bus.level_o, 32'h03E8_03E8);

    // Alternating sign with random gaps
    do_clear();
    check("clear_level", bus.level_o, 32'h0);
    for (int i = 0; i < WIN - 1; i++) send((i % 2 == 0) ? 1000 : -1000, 3);
    tick();
    tick();
    check("alt_no_early_pulse", 32'(pulse_cnt), 32'(exp_pulses));
    send(-1000, 3);
    window_done("alt");
    check("alt_level_lit", last_level, 32'h03E8_03E8);

    // Saturation of -32768
    do_clear();
    for (int i = 0; i < WIN; i++) send(-32768, 0);
    window_done("sat");
    check("sat_level_lit", last_level, 32'h7FFF_7FFF);

    // Peak-hold decay over zero windows
    do_clear();
    for (int i = 0; i < WIN; i++) send(16'h4000, 1);
    window_done("decay0");
    check("decay0_lit", last_level, 32'h4000_4000);
    for (int i = 0; i < WIN; i++) send(0, 1);
    window_done("decay1");
    check("decay1_lit", last_level, 32'h3000_0000);
    for (int i = 0; i < WIN; i++) send(0, 0);
    window_done("decay2");
    check("decay2_lit", last_level, 32'h2400_0000);
    for (int i = 0; i < WIN; i++) send(0, 2);
    window_done("decay3");
    check("decay3_lit", last_level, 32'h1B00_0000);

    // Reset mid-window, with a colliding strobe and an in-flight sample
    for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 65535)) - 32768, 0);
    rst                = 1'b1;
    bus.sample_i       = 16'sd9999;
    bus.sample_valid_i = 1'b1;
    tick();
    rst                = 1'b0;
    bus.sample_valid_i = 1'b0;
    model_clear();
    tick();
    check("rst_mid_level", bus.level_o, 32'h0);
    check("rst_mid_no_pulse", 32'(pulse_cnt), 32'(exp_pulses));
    for (int i = 0; i < WIN; i++) send(5, 1);
    window_done("rst_win");
    check("rst_win_lit", last_level, 32'h0005_0005);

    // Clear colliding with a strobe while another sample is in stage 1
    bus.sample_i       = 16'sd1234;
    bus.sample_valid_i = 1'b1;
    tick();
    bus.sample_i       = -16'sd777;
    bus.clear_i        = 1'b1;
    tick();
    bus.clear_i        = 1'b0;
    bus.sample_valid_i = 1'b0;
    model_clear();
    tick();
    check("clr_col_level", bus.level_o, 32'h0);
    check("clr_col_valid", 32'(bus.level_valid_o), 32'h0);
    for (int i = 0; i < WIN - 1; i++) send(int'($urandom_range(0, 65535)) - 32768, 2);
    tick();
    tick();
    check("clr_col_no_early", 32'(pulse_cnt), 32'(exp_pulses));
    send(int'($urandom_range(0, 65535)) - 32768, 2);
    window_done("clr_col_win");

    // Randomized windows, peak hold carried across windows
    for (int w = 0; w < 8; w++) begin
      for (int i = 0; i < WIN; i++) begin
        s = int'($urandom_range(0, 65535)) - 32768;
        if ($urandom_range(0, 15) == 0) s = -32768;
        if (w >= 5) s = s / 64;
        send(s, 2);
      end
      window_done($sformatf("rand_w%0d", w));
    end

    repeat (5) tick();
    check("final_pulses", 32'(pulse_cnt), 32'(exp_pulses));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mic_level_meter.md
# mic_level_meter

Computes a windowed loudness measurement from the audio sample stream and drives the 32-bit `mic_level` probe input of the debug core. Each window of 2^WINDOW_LOG2 accepted samples yields a mean absolute amplitude and a decaying peak-hold value. Both are packed into one word that is updated once per window, so the host reads a stable value over the UART bridge.

## Interface
- `WINDOW_LOG2`, default 10: log2 of samples per window. Legal range 1..16.
- `DECAY_SHIFT`, default 3: peak-hold decay per window is `hold >> DECAY_SHIFT`. Legal range 1..15.
- `clk`  in  1: single clock, shared with the debug core.
- `rst`  in  1: synchronous, active-high reset.
- `sample_i`  in  16: signed two's-complement PCM sample.
- `sample_valid_i`  in  1: one-cycle strobe; `sample_i` is taken when high. Strobes may arrive back-to-back.
- `clear_i`  in  1: synchronous restart of the measurement.
- `level_o`  out  32: `{peak_hold[15:0], mean_abs[15:0]}`, both unsigned.
- `level_valid_o`  out  1: one-cycle pulse when `level_o` updates.

## Operation
- **Stage 1 (abs).**
  - On `sample_valid_i`: `abs_q <= |sample_i|`, saturated, so -32768 becomes 0x7FFF.
  - `abs_v` is registered alongside `abs_q`.
- **Stage 2 (window), on `abs_v`:**
  - `acc += abs_q`. `acc` is 16+WINDOW_LOG2 bits wide and cannot overflow.
  - `win_peak = max(win_peak, abs_q)`.
  - `cnt` increments.
- **Window end.** Occurs when `abs_v` is high and `cnt == 2^WINDOW_LOG2-1`. On that edge:
  - `mean_abs = (acc + abs_q) >> WINDOW_LOG2`. This is truncation; the result always fits in 16 bits.
  - `new_peak = max(win_peak', hold - (hold >> DECAY_SHIFT))`, where `win_peak'` includes the current `abs_q`.
  - `hold <= new_peak`.
  - `level_o <= {new_peak, mean_abs}`.
  - `level_valid_o <= 1`.
  - `acc`, `win_peak` and `cnt` all return to 0.
- **Outside window end**, `level_o` holds its value and `level_valid_o` is 0.
- **States:**
  - `FILL` is the only state: counting samples.
  - The window-end event is a transition `FILL -> FILL` with an output commit. No idle state is needed.
- **Reset.** Reset values: `abs_q`=0, `abs_v`=0, `acc`=0, `cnt`=0, `win_peak`=0, `hold`=0, `level_o`=0, `level_valid_o`=0.
- **`clear_i`.** Same effect as `rst` on all state, including `level_o`=0 and `hold`=0.
- **Boundaries:**
  - `clear_i` or `rst` together with `sample_valid_i`: the sample is dropped, and any in-flight `abs_v` sample is dropped. Clear/reset wins.
  - Reset mid-window discards the partial window. No `level_valid_o` pulse is produced for it.
  - All-zero input: after the first window, `mean_abs`=0 and `hold` decays toward 0.
  - Decay stalls at `hold < 2^DECAY_SHIFT`, because the shift yields 0. This is accepted behaviour.
  - No sample gaps are required: gaps stall counting and never emit partial windows.

## Timing
- **Throughput.** One sample per cycle, sustained. Cycles without a strobe are gaps.
- **Latency.** A strobe sampled at edge E enters stage 2 at edge E+1.
  - If it is the last sample of the window, `level_o` and `level_valid_o` are visible after edge E+1, i.e. 2 edges from input to output.
- **Pulse rate.** `level_valid_o` pulses exactly once per 2^WINDOW_LOG2 accepted samples.
- **Consumer timing.** `level_o` is stable for at least 2^WINDOW_LOG2 cycles between updates, which is safe for the debug core's strobe-sampled buffer.
- **No backpressure.** There is no ready signal; every strobe is consumed.
- **Output style.** All outputs are registered; there are no combinational paths from input to output.

## Structure
- **Package `mic_level_pkg`:**
  - `SAMPLE_W`=16 and `LEVEL_W`=32.
  - The function `sat_abs(logic signed [15:0]) -> [15:0]`.
  - The function `umax16`.
- **Sub-module `level_window_acc`.** Stage 2 (`acc`, `cnt`, `win_peak`, window-end detect) is a natural sub-module.
  - It outputs `mean_abs`, `win_peak'` and an `end` strobe.
  - The top module keeps stage 1, the peak-hold/decay logic and the output register.

## Test plan
- **Constant input.** WINDOW_LOG2=4, 16 strobes of +1000 back-to-back -> one pulse 2 edges after the last strobe, `level_o`=0x03E8_03E8.
- **Sign handling and gaps.** Alternating +1000/-1000 with random gaps -> `level_o`=0x03E8_03E8. A pulse appears only after the 16th accepted sample.
- **Saturation.** 16 samples of -32768 -> `level_o`=0x7FFF_7FFF, with no accumulator wrap.
- **Decay.** DECAY_SHIFT=2: one window at 0x4000, then zero windows -> peak field sequence 0x4000, 0x3000, 0x2400, 0x1B00; mean field 0x0000 after the first window.
- **Reset mid-window.** `rst` after 10 of 16 samples, then 16 samples of +5 -> single pulse with `level_o`=0x0005_0005. No pulse occurs for the aborted window.
- **Clear collision.** `clear_i` and `sample_valid_i` asserted in the same cycle, with a sample also in flight in stage 1 -> both samples discarded and `level_o`=0. The next full window counts from a fresh start.
